// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU operation sequencer.
//   - seq_state_t  : sequencer FSM states
//   - shift_type_t : shift/rotate kind carried by a shift command
//   - OP_*         : ALU operation codes
//   - SINGLE_STEPS / PAIR_STEPS : 2-bit beats per 8-bit / 16-bit pass
//   - plan_shift() : splits a bit count into 2-bit steps plus an odd 1-bit pass
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  localparam int SINGLE_STEPS = 4;
  localparam int PAIR_STEPS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ROR1 = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    SH_ROR = 2'd0,
    SH_SHR = 2'd1,
    SH_SAR = 2'd2,
    SH_SHL = 2'd3
  } shift_type_t;

  // Returns {k[2:0], odd}: k 2-bit steps for the timed pass, odd selects
  // the trailing 1-bit pass. Single registers only rotate modulo 8.
  function automatic logic [3:0] plan_shift(input logic [3:0] count, input logic pair);
    logic [3:0] c;
    c = count & (pair ? 4'd15 : 4'd7);
    return {c[3:1], c[0]};
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to the bit-serial ALU / register file.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cmd_*                   command fields, valid/ready handshake (ready only in IDLE)
//   ext_data_valid          external operand beat present this cycle
//   alu_op_done             ALU signals its last step of the current pass
//   alu_*                   ALU control lines, zero outside RUN/ROR1
//   resp_valid              one-cycle pulse when the command retires
//   busy                    sequencer not idle
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int LOG2_NR    = 4,
  parameter int OP_BITS    = 3,
  parameter int STATE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_shift,
  input  logic [OP_BITS-1:0]    cmd_op,
  input  logic [1:0]            cmd_shift_type,
  input  logic [3:0]            cmd_count,
  input  logic [LOG2_NR-1:0]    cmd_reg1,
  input  logic [LOG2_NR-1:0]    cmd_reg2,
  input  logic                  cmd_pair,
  input  logic                  cmd_ext_arg2,
  input  logic                  cmd_update_flags,
  input  logic                  ext_data_valid,
  input  logic                  alu_op_done,
  output logic [OP_BITS-1:0]    alu_operation,
  output logic [LOG2_NR-1:0]    alu_reg1,
  output logic [LOG2_NR-1:0]    alu_reg2,
  output logic                  alu_pair_op,
  output logic                  alu_pair_op2,
  output logic                  alu_update_reg1,
  output logic                  alu_external_arg2,
  output logic                  alu_regfile_en,
  output logic                  alu_advance,
  output logic                  alu_rotate,
  output logic                  alu_timed_rotate,
  output logic                  alu_do_ror1,
  output logic                  alu_last_ror1,
  output logic                  alu_do_shr,
  output logic                  alu_do_sar,
  output logic                  alu_do_shl,
  output logic [STATE_BITS-1:0] alu_rotate_count,
  output logic                  alu_update_carry_flags,
  output logic                  alu_update_other_flags,
  output logic                  resp_valid,
  output logic                  busy
);

  localparam logic [2:0] SINGLE_LAST = 3'(SINGLE_STEPS - 1);
  localparam logic [2:0] PAIR_LAST   = 3'(PAIR_STEPS - 1);

  seq_state_t state_reg, state_next;

  logic [OP_BITS-1:0] op_reg;
  logic [LOG2_NR-1:0] reg1_reg, reg2_reg;
  shift_type_t        type_reg;
  logic [2:0]         k_reg;
  logic               shift_reg, pair_reg, ext_reg, upd_reg, odd_reg;
  logic [2:0]         beat_reg, beat_next;

  logic [3:0] plan;
  logic       accept, run, ror, active, advance, last_beat, final_pass;

  assign plan   = plan_shift(cmd_count, cmd_pair);
  assign accept = cmd_valid && (state_reg == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      op_reg    <= '0;
      reg1_reg  <= '0;
      reg2_reg  <= '0;
      type_reg  <= SH_ROR;
      k_reg     <= '0;
      shift_reg <= 1'b0;
      pair_reg  <= 1'b0;
      ext_reg   <= 1'b0;
      upd_reg   <= 1'b0;
      odd_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (accept) begin
        op_reg    <= cmd_op;
        reg1_reg  <= cmd_reg1;
        reg2_reg  <= cmd_reg2;
        type_reg  <= shift_type_t'(cmd_shift_type);
        k_reg     <= plan[3:1];
        shift_reg <= cmd_shift;
        pair_reg  <= cmd_pair;
        ext_reg   <= cmd_ext_arg2;
        upd_reg   <= cmd_update_flags;
        // ALU ops never take the 1-bit pass, so their final pass is RUN.
        odd_reg   <= cmd_shift && plan[0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;

    run        = (state_reg == ST_RUN);
    ror        = (state_reg == ST_ROR1);
    active     = run || ror;
    // External-operand commands only step when a data beat is present.
    advance    = active && (!ext_reg || ext_data_valid);
    last_beat  = (beat_reg == (pair_reg ? PAIR_LAST : SINGLE_LAST));
    final_pass = (run && !odd_reg) || ror;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_shift || (plan[3:1] != 3'd0)) state_next = ST_RUN;
          else if (plan[0])                      state_next = ST_ROR1;
          else                                   state_next = ST_DONE;
        end
      end
      ST_RUN: begin
        // A done indication during a stall is not the real last step.
        if (advance && alu_op_done) state_next = (shift_reg && odd_reg) ? ST_ROR1 : ST_DONE;
      end
      ST_ROR1: begin
        if (advance) begin
          if (last_beat) begin
            state_next = ST_DONE;
            beat_next  = '0;
          end else begin
            beat_next = beat_reg + 3'd1;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    cmd_ready              = (state_reg == ST_IDLE);
    busy                   = (state_reg != ST_IDLE);
    resp_valid             = (state_reg == ST_DONE);

    alu_operation          = (active && !shift_reg) ? op_reg : '0;
    alu_reg1               = active ? reg1_reg : '0;
    alu_reg2               = active ? reg2_reg : '0;
    alu_pair_op            = active && pair_reg;
    alu_pair_op2           = active && pair_reg && !shift_reg;
    alu_update_reg1        = run && !shift_reg;
    alu_external_arg2      = active && ext_reg;
    alu_regfile_en         = advance;
    alu_advance            = advance;
    alu_rotate             = active && shift_reg;
    alu_timed_rotate       = run && shift_reg;
    alu_do_ror1            = ror;
    alu_last_ror1          = ror && last_beat;
    alu_do_shr             = active && shift_reg && (type_reg == SH_SHR);
    alu_do_sar             = active && shift_reg && (type_reg == SH_SAR);
    alu_do_shl             = active && shift_reg && (type_reg == SH_SHL);
    alu_rotate_count       = (run && shift_reg) ? STATE_BITS'(k_reg) : '0;
    alu_update_carry_flags = final_pass && upd_reg;
    alu_update_other_flags = final_pass && upd_reg;
  end

endmodule
